// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Accepts one M-extension op from ID/EX, stalls the front of
//               the pipeline while it iterates one bit per cycle, then
//               presents a registered result for exactly one cycle.
//               Fixed latency: 33 cycles from acceptance to done.
//
// Ports       : clk        clock, rising edge
//               rst        synchronous active-high reset
//               start      ID/EX holds a valid M-op this cycle
//               op[2:0]    RV32M funct3 (MUL..REMU)
//               op_a/op_b  forwarded rs1/rs2 operands
//               rd_in      destination register of the op
//               flush      aborts the op in flight (BUSY only)
//               stall_req  freeze IF/ID and ID/EX (combinational)
//               busy       unit is iterating
//               done       one-cycle result-valid pulse
//               result     registered result, valid while done=1
//               rd_out     registered destination, valid while done=1
//
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int                c_CW   = $clog2(ITER);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(ITER - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a_mag;
    logic [XLEN-1:0]   r_b_mag;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_div_zero;
    logic [2*XLEN-1:0] r_acc;
    logic [c_CW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    // ------------------------------------------------------------------
    // Operand conditioning at acceptance
    // ------------------------------------------------------------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_accept;

    always_comb begin
        w_a_signed = (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                     (op == c_OP_DIV)  || (op == c_OP_REM);
        w_b_signed = (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
        w_a_neg    = w_a_signed & op_a[XLEN-1];
        w_b_neg    = w_b_signed & op_b[XLEN-1];
        w_a_mag    = w_a_neg ? (~op_a + 1'b1) : op_a;
        w_b_mag    = w_b_neg ? (~op_b + 1'b1) : op_b;
    end

    assign w_accept = (r_state == c_IDLE) && start && !flush;

    // ------------------------------------------------------------------
    // One iteration step. Both algorithms walk the operand bits MSB first
    // so they can share a single bit index derived from the counter.
    // ------------------------------------------------------------------
    logic [c_CW-1:0]   w_idx;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;

    always_comb begin
        w_idx      = c_LAST - r_cnt;

        // Multiply: acc = 2*acc + (b_bit ? a : 0)
        w_mul_next = {r_acc[2*XLEN-2:0], 1'b0} +
                     (r_b_mag[w_idx] ? {{XLEN{1'b0}}, r_a_mag} : {2*XLEN{1'b0}});

        // Divide: acc holds {remainder, quotient}; bring down the next
        // dividend bit and keep the trial difference if it is non-negative.
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a_mag[w_idx]};
        w_trial    = w_rem_sh - {1'b0, r_b_mag};
        if (!w_trial[XLEN]) begin
            w_div_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end

        w_acc_next = r_op[2] ? w_div_next : w_mul_next;
    end

    // ------------------------------------------------------------------
    // Final result, evaluated on the last iteration and registered on the
    // BUSY->DONE edge. A zero divisor leaves the dividend magnitude in the
    // remainder, so REM/REMU return op_a without a special case; only the
    // quotient needs forcing, since sign correction would otherwise turn
    // the all-ones quotient into 1 for a negative dividend.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    always_comb begin
        w_prod_fix = r_neg_res ? (~w_acc_next + 1'b1) : w_acc_next;
        w_quo      = w_acc_next[XLEN-1:0];
        w_rem      = w_acc_next[2*XLEN-1:XLEN];
        w_final    = w_rem;
        case (r_op)
            c_OP_MUL:    w_final = w_prod_fix[XLEN-1:0];
            c_OP_MULH,
            c_OP_MULHSU,
            c_OP_MULHU:  w_final = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV:    w_final = r_div_zero ? {XLEN{1'b1}}
                                              : (r_neg_res ? (~w_quo + 1'b1) : w_quo);
            c_OP_DIVU:   w_final = r_div_zero ? {XLEN{1'b1}} : w_quo;
            c_OP_REM:    w_final = r_neg_rem ? (~w_rem + 1'b1) : w_rem;
            default:     w_final = w_rem;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (start && !flush) begin
                    w_next_state = c_BUSY;
                end
            end
            c_BUSY: begin
                if (flush) begin
                    w_next_state = c_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_next_state = c_DONE;
                end
            end
            // The accepted instruction still sits in ID/EX during DONE,
            // so start is not looked at here.
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_rd       <= '0;
            r_a_mag    <= '0;
            r_b_mag    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_rd_out   <= '0;
        end else if (w_accept) begin
            r_op       <= op;
            r_rd       <= rd_in;
            r_a_mag    <= w_a_mag;
            r_b_mag    <= w_b_mag;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= op[2] & w_a_neg;
            r_div_zero <= (op_b == '0);
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if ((r_state == c_BUSY) && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + c_CW'(1);
            if (r_cnt == c_LAST) begin
                r_result <= w_final;
                r_rd_out <= r_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (r_state == c_BUSY);
    assign done      = (r_state == c_DONE);
    assign stall_req = w_accept || (r_state == c_BUSY);
    assign result    = r_result;
    assign rd_out    = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv. A vector table drives
//               back-to-back ops; expected results go into a scoreboard
//               queue at issue and are compared when done pulses. Hand
//               sequences cover flush, reset and held-start corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

    localparam logic [2:0] c_MUL    = 3'd0;
    localparam logic [2:0] c_MULH   = 3'd1;
    localparam logic [2:0] c_MULHSU = 3'd2;
    localparam logic [2:0] c_MULHU  = 3'd3;
    localparam logic [2:0] c_DIV    = 3'd4;
    localparam logic [2:0] c_DIVU   = 3'd5;
    localparam logic [2:0] c_REM    = 3'd6;
    localparam logic [2:0] c_REMU   = 3'd7;
    localparam int         c_NVEC   = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .ITER(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } sb_t;

    vec_t vecs [c_NVEC];
    sb_t  sb_q [$];
    sb_t  sb_e;
    int   n_vec    = 0;
    int   n_miscmp = 0;
    int   n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest issued op.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miscmp++;
                $display("FAIL unexpected_done: got result 0x%08h rd %0d, expected no done (t=%0t)",
                         result, rd_out, $time);
            end else begin
                sb_e = sb_q.pop_front();
                check("result", result, sb_e.res);
                check("rd_out", {27'd0, rd_out}, {27'd0, sb_e.rd});
            end
        end
    end

    // Called at a negedge (cycle 0). Returns just after the accepting edge.
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit expect_res);
        sb_t e;
        op    = o;
        op_a  = a;
        op_b  = b;
        rd_in = rd;
        start = 1'b1;
        #1;
        check("stall_req_c0", {31'd0, stall_req}, 32'd1);
        if (expect_res) begin
            e.rd  = rd;
            e.res = exp;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles after acceptance until done; checks latency and that
    // stall_req/busy stay high on every iteration cycle.
    task automatic wait_done(input int exp_lat);
        int c    = 0;
        bit seen = 1'b0;
        bit bad  = 1'b0;
        while (!seen && c < 45) begin
            @(negedge clk);
            c++;
            if (done === 1'b1) begin
                seen = 1'b1;
                check("latency", c, exp_lat);
                check("stall_req_done", {31'd0, stall_req}, 32'd0);
            end else if (!(stall_req === 1'b1 && busy === 1'b1)) begin
                bad = 1'b1;
            end
        end
        if (!seen) begin
            n_vec++;
            n_miscmp++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done at %0d", c, exp_lat);
        end
        check("stall_busy_iter", {31'd0, bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;

        vecs[0]  = '{c_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
        vecs[1]  = '{c_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
        vecs[2]  = '{c_MULHSU, 32'h8000_0000, 32'h8000_0000, 5'd3,  32'hC000_0000};
        vecs[3]  = '{c_MULHU,  32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000};
        vecs[4]  = '{c_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD};
        vecs[5]  = '{c_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{c_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'h7FFF_FFFC};
        vecs[7]  = '{c_DIV,    32'h0000_0005, 32'h0000_0000, 5'd8,  32'hFFFF_FFFF};
        vecs[8]  = '{c_REMU,   32'h0000_0005, 32'h0000_0000, 5'd9,  32'h0000_0005};
        vecs[9]  = '{c_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
        vecs[10] = '{c_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000};
        vecs[11] = '{c_MUL,    32'h1234_5678, 32'h0000_0010, 5'd12, 32'h2345_6780};
        vecs[12] = '{c_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE};
        vecs[13] = '{c_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
        vecs[14] = '{c_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'hFFFF_FFFF};
        vecs[15] = '{c_DIVU,   32'd100,       32'd7,         5'd16, 32'd14};
        vecs[16] = '{c_REMU,   32'd100,       32'd7,         5'd17, 32'd2};
        vecs[17] = '{c_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD};
        vecs[18] = '{c_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd19, 32'h0000_0001};
        vecs[19] = '{c_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 5'd20, 32'hFFFF_FFFF};
        vecs[20] = '{c_REM,    32'hFFFF_FFF9, 32'h0000_0000, 5'd21, 32'hFFFF_FFF9};
        vecs[21] = '{c_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd22, 32'hFFFF_FFFF};
        vecs[22] = '{c_REMU,   32'hDEAD_BEEF, 32'h0000_0010, 5'd23, 32'h0000_000F};
        vecs[23] = '{c_MUL,    32'h0000_0000, 32'h1234_5678, 5'd24, 32'h0000_0000};

        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        op_a  = '0;
        op_b  = '0;
        rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_done",   {31'd0, done},      32'd0);
        check("rst_stall",  {31'd0, stall_req}, 32'd0);
        check("rst_result", result,             32'd0);
        check("rst_rd_out", {27'd0, rd_out},    32'd0);

        // Table: back-to-back ops, each issued the cycle after the previous done.
        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b1);
            wait_done(33);
        end

        // start together with flush in IDLE must not be accepted.
        @(negedge clk);
        op = c_MUL; op_a = 32'd3; op_b = 32'd3; rd_in = 5'd7;
        start = 1'b1;
        flush = 1'b1;
        #1;
        check("idle_flush_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", {31'd0, busy}, 32'd0);

        // Flush at cycle 10 of a DIV, then a MUL accepted at cycle 11.
        @(negedge clk);
        launch(c_DIV, 32'd100, 32'd7, 5'd25, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",  {31'd0, busy},      32'd0);
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        check("flush_done",  {31'd0, done},      32'd0);
        @(negedge clk);
        launch(c_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd26, 32'hFFFF_FFEB, 1'b1);
        wait_done(33);

        // Reset at cycle 20 of a MUL: clean idle, cleared result, no done.
        @(negedge clk);
        launch(c_MUL, 32'h1234_5678, 32'd3, 5'd27, 32'd0, 1'b0);
        d0 = n_done;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy",   {31'd0, busy},      32'd0);
        check("mrst_done",   {31'd0, done},      32'd0);
        check("mrst_stall",  {31'd0, stall_req}, 32'd0);
        check("mrst_result", result,             32'd0);
        check("mrst_rd_out", {27'd0, rd_out},    32'd0);
        repeat (40) @(negedge clk);
        check("mrst_no_done", n_done - d0, 32'd0);

        // start held high from acceptance through DONE: one op, one done.
        @(negedge clk);
        d0 = n_done;
        op = c_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0002; rd_in = 5'd28;
        start = 1'b1;
        sb_e.rd  = 5'd28;
        sb_e.res = 32'h0000_0001;
        sb_q.push_back(sb_e);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 33) begin
                check("hold_done_c33",  {31'd0, done},      32'd1);
                check("hold_stall_c33", {31'd0, stall_req}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (45) @(negedge clk);
        check("hold_one_done", n_done - d0, 32'd1);
        check("hold_busy_end", {31'd0, busy}, 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It accepts an M-extension operation with its operands and destination register. It holds the front of the pipeline with a stall request while it iterates, then presents a one-cycle result to the EX/MEM path. Every operation has a fixed latency of 33 cycles from acceptance to result.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, number of iteration cycles; must equal XLEN.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  ID/EX holds a valid M-op this cycle.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  32  rs1 operand, already forwarded.
- op_b  in  32  rs2 operand, already forwarded.
- rd_in  in  5  destination register of the op.
- flush  in  1  branch/jump flush; aborts the op in flight.
- stall_req  out  1  freeze IF/ID and ID/EX; combinational.
- busy  out  1  state is BUSY.
- done  out  1  result valid this cycle (one-cycle pulse).
- result  out  32  final 32-bit result; valid only while done=1.
- rd_out  out  5  destination of result; valid while done=1.

## Operation
- States: IDLE, BUSY, DONE. Encoding is implementation choice.
- IDLE to BUSY when start=1 and flush=0. On entry:
  - Latch op and rd_in.
  - Latch operand magnitudes, with the signedness set by op. MULH: a and b signed. MULHSU: a signed, b unsigned. DIV/REM: both signed. Other ops: unsigned.
  - Latch the sign flags: neg_res (product or quotient) and neg_rem (equals the dividend sign).
  - Latch div_zero = (op_b==0).
  - Clear the 64-bit accumulator and set cnt=0.
- BUSY: one iteration per cycle, with cnt incrementing 0..31.
  - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit unsigned product.
  - Divide: restoring radix-2, one quotient bit per cycle, producing a 32-bit quotient and remainder.
  - BUSY to DONE on the cycle cnt==31.
- DONE to IDLE unconditionally. start is ignored in DONE, because the same instruction is still in ID/EX.
- Result selection in DONE:
  - MUL: low 32 bits of the product, negated as 64-bit if neg_res.
  - MULH/MULHSU/MULHU: high 32 bits of the signed-corrected 64-bit product.
  - DIV/DIVU: quotient, two's-complement negated if neg_res (DIV only).
  - REM/REMU: remainder, negated if neg_rem (REM only).
- Divide by zero (div_zero=1):
  - DIV/DIVU result = 0xFFFFFFFF.
  - REM/REMU result = original op_a.
  - Latency is unchanged.
- Signed overflow: DIV 0x80000000 / -1 = 0x80000000 and REM = 0. This falls out of the magnitude path and needs no special case.
- flush=1 in BUSY: next state IDLE, no done, latched rd discarded.
- flush in IDLE: start ignored.
- flush in DONE: no effect; done still pulses, and the downstream flush squashes it.
- rst=1 in any state: IDLE next edge, all internal registers cleared; overrides start and flush.
- stall_req = (IDLE & start & ~flush) | BUSY. It is deasserted in DONE so the pipeline advances at the end of the DONE cycle.

## Timing
- Reset values: busy=0, done=0, stall_req=0 (with start=0), result=0, rd_out=0.
- Cycle 0: IDLE, start=1, so stall_req=1.
- Cycles 1..32: BUSY, stall_req=1, busy=1.
- Cycle 33: DONE, done=1 with result/rd_out valid, stall_req=0.
- Cycle 34: IDLE. A new start may be accepted in cycle 34; back-to-back ops therefore have a throughput of 1 per 34 cycles.
- result and rd_out are registered. They hold their last value outside DONE and must not be consumed unless done=1.
- Flush in BUSY at cycle k: IDLE at k+1, stall_req=0 from k+1.

## Test plan
- MUL 7 × -3 (op_a=0x00000007, op_b=0xFFFFFFFD) -> done at cycle 33, result=0xFFFFFFEB. Check stall_req high in cycles 0–32 and low in cycle 33.
- MULH/MULHSU/MULHU with op_a=op_b=0x80000000:
  - MULH -> 0x40000000.
  - MULHSU -> 0xC0000000.
  - MULHU -> 0x40000000.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0x00000000.
  - All at latency 33.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, no done pulse, stall_req=0. A new MUL accepted at cycle 11 returns the correct result at cycle 44.
- rst asserted at cycle 20 of a MUL -> IDLE, busy=0, result=0 next cycle, no done. start held high through DONE -> only one op executed and exactly one done pulse.
